// File: rtl/sample_sched_pkg.sv
// Shared types for the sample scheduler: FSM state encoding and state helpers.
package sample_sched_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // States in which the phase counter advances and tx strobes may fire.
    function automatic logic is_counting(input state_t s);
        return (s == RUN) || (s == DRAIN);
    endfunction

endpackage : sample_sched_pkg

// File: rtl/sample_sched_win_cnt.sv
// Measurement-window counter: counts tx symbols and flags the symbol that
// completes a window of 2^NB_WINDOW, then wraps.
module sample_sched_win_cnt #(
    parameter int unsigned NB_WINDOW = 10
) (
    input  logic clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_done
);

    logic [NB_WINDOW-1:0] win_q;

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            win_q <= '0;
        end else if (i_clear) begin
            win_q <= '0;
        end else if (i_inc) begin
            win_q <= win_q + NB_WINDOW'(1);
        end
    end

    // Done coincides with the increment that wraps the counter.
    assign o_done = i_inc && (&win_q);

endmodule : sample_sched_win_cnt

// File: rtl/sample_sched.sv
// Oversampled symbol scheduler: issues tx symbol strobes and phase-selectable
// rx sampling strobes. Define SAMPLE_SCHED_WINDOW_EN to add window counting.
module sample_sched
    import sample_sched_pkg::*;
#(
    parameter int unsigned NB_COUNT  = 2,
    parameter int unsigned NB_WINDOW = 10
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic [NB_COUNT-1:0] i_phase,
    output logic                o_valid_tx,
    output logic                o_valid_rx,
    output logic                o_window_done,
    output logic                o_busy,
    output logic [STATE_W-1:0]  o_state
);

    state_t              state_q;
    state_t              state_d;
    logic [NB_COUNT-1:0] cnt_q;
    logic [NB_COUNT-1:0] phase_q;
    logic                cnt_max_c;
    logic                counting_c;
    logic                valid_tx_c;
    logic                valid_rx_c;
    logic                window_done_c;

    assign cnt_max_c  = &cnt_q;
    assign counting_c = i_enable && is_counting(state_q);

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and strobes; strobes depend only on registered state plus i_enable.
    always_comb begin
        state_d    = state_q;
        valid_tx_c = 1'b0;
        valid_rx_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start && i_enable && !i_stop) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                state_d = i_stop ? IDLE : RUN;
            end
            RUN: begin
                valid_tx_c = i_enable && cnt_max_c;
                valid_rx_c = i_enable && (cnt_q == phase_q);
                if (i_stop) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                valid_tx_c = i_enable && cnt_max_c;
                if (valid_tx_c) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Phase counter and sampling phase; phase only reloads at the symbol wrap
    // so each symbol period sees exactly one rx strobe.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q   <= '0;
            phase_q <= '0;
        end else if (state_q == ARM) begin
            cnt_q   <= '0;
            phase_q <= i_phase;
        end else if (counting_c) begin
            cnt_q <= cnt_q + NB_COUNT'(1);
            if ((state_q == RUN) && cnt_max_c) begin
                phase_q <= i_phase;
            end
        end
    end

`ifdef SAMPLE_SCHED_WINDOW_EN
    sample_sched_win_cnt #(
        .NB_WINDOW (NB_WINDOW)
    ) u_win_cnt (
        .clock   (clock),
        .i_reset (i_reset),
        .i_clear (state_q == ARM),
        .i_inc   (valid_tx_c),
        .o_done  (window_done_c)
    );
`else
    logic unused_nb_window;

    assign unused_nb_window = ^NB_WINDOW;
    assign window_done_c    = 1'b0;
`endif

    assign o_valid_tx    = valid_tx_c;
    assign o_valid_rx    = valid_rx_c;
    assign o_window_done = window_done_c;
    assign o_busy        = (state_q != IDLE);
    assign o_state       = STATE_W'(state_q);

endmodule : sample_sched

// File: tb/tb_sample_sched.sv
// Directed bench for sample_sched (NB_COUNT=2, NB_WINDOW=3) with a per-cycle
// expected-output queue fed by a reference model plus hand-derived strobe maps.
module tb_sample_sched;

    localparam int unsigned NB_COUNT  = 2;
    localparam int unsigned NB_WINDOW = 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARM   = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

`ifdef SAMPLE_SCHED_WINDOW_EN
    localparam bit WIN_EN = 1'b1;
`else
    localparam bit WIN_EN = 1'b0;
`endif

    logic       clock;
    logic       i_reset;
    logic       i_enable;
    logic       i_start;
    logic       i_stop;
    logic [1:0] i_phase;
    logic       o_valid_tx;
    logic       o_valid_rx;
    logic       o_window_done;
    logic       o_busy;
    logic [1:0] o_state;

    sample_sched #(
        .NB_COUNT  (NB_COUNT),
        .NB_WINDOW (NB_WINDOW)
    ) dut (
        .clock         (clock),
        .i_reset       (i_reset),
        .i_enable      (i_enable),
        .i_start       (i_start),
        .i_stop        (i_stop),
        .i_phase       (i_phase),
        .o_valid_tx    (o_valid_tx),
        .o_valid_rx    (o_valid_rx),
        .o_window_done (o_window_done),
        .o_busy        (o_busy),
        .o_state       (o_state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int          checks = 0;
    int          errors = 0;
    logic [5:0]  exp_q[$];

    logic [1:0]  m_state;
    logic [1:0]  m_cnt;
    logic [1:0]  m_phq;
    logic [2:0]  m_win;
    int          rc;
    logic [31:0] tx_mask;
    logic [31:0] rx_mask;
    logic [31:0] wd_mask;
    logic [31:0] busy_mask;

    // Expected {tx, rx, window_done, busy, state} for the current cycle.
    function automatic logic [5:0] model_out(input logic rst, input logic en);
        logic tx, rx, wd;
        if (!rst) return 6'b0;
        tx = ((m_state == S_RUN) || (m_state == S_DRAIN)) && en && (m_cnt == 2'd3);
        rx = (m_state == S_RUN) && en && (m_cnt == m_phq);
        wd = WIN_EN && tx && (m_win == 3'd7);
        return {tx, rx, wd, (m_state != S_IDLE), m_state};
    endfunction

    function automatic void model_step(input logic rst, input logic en, input logic st,
                                       input logic sp, input logic [1:0] ph);
        logic       tx;
        logic [1:0] nxt;
        if (!rst) begin
            m_state = S_IDLE;
            m_cnt   = 2'd0;
            m_phq   = 2'd0;
            m_win   = 3'd0;
            rc      = rc + 1;
            return;
        end
        tx  = ((m_state == S_RUN) || (m_state == S_DRAIN)) && en && (m_cnt == 2'd3);
        nxt = m_state;
        case (m_state)
            S_IDLE:  if (st && en && !sp) nxt = S_ARM;
            S_ARM: begin
                m_cnt = 2'd0;
                m_phq = ph;
                m_win = 3'd0;
                nxt   = sp ? S_IDLE : S_RUN;
            end
            S_RUN:   if (sp) nxt = S_DRAIN;
            default: if (tx) nxt = S_IDLE;
        endcase
        if (((m_state == S_RUN) || (m_state == S_DRAIN)) && en) begin
            if ((m_state == S_RUN) && (m_cnt == 2'd3)) m_phq = ph;
            m_cnt = m_cnt + 2'd1;
        end
        if (tx) m_win = m_win + 3'd1;
        rc      = ((m_state == S_ARM) && (nxt == S_RUN)) ? 0 : rc + 1;
        m_state = nxt;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, queue the expectation, compare, then advance the model.
    task automatic cyc(input logic rst, input logic en, input logic st, input logic sp,
                       input logic [1:0] ph);
        logic [5:0] obs;
        logic [5:0] e;
        i_reset  = rst;
        i_enable = en;
        i_start  = st;
        i_stop   = sp;
        i_phase  = ph;
        #1;
        exp_q.push_back(model_out(rst, en));
        obs = {o_valid_tx, o_valid_rx, o_window_done, o_busy, o_state};
        e   = exp_q.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL outputs rc=%0d observed=%b expected=%b", rc, obs, e);
        end
        if (rc >= 0 && rc < 32) begin
            if (o_valid_tx)    tx_mask[rc[4:0]]   = 1'b1;
            if (o_valid_rx)    rx_mask[rc[4:0]]   = 1'b1;
            if (o_window_done) wd_mask[rc[4:0]]   = 1'b1;
            if (o_busy)        busy_mask[rc[4:0]] = 1'b1;
        end
        @(posedge clock);
        model_step(rst, en, st, sp, ph);
        #1;
    endtask

    task automatic clr_logs();
        tx_mask   = '0;
        rx_mask   = '0;
        wd_mask   = '0;
        busy_mask = '0;
        rc        = 1000;
    endtask

    task automatic start_run(input logic [1:0] ph);
        clr_logs();
        cyc(1'b1, 1'b1, 1'b1, 1'b0, ph);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, ph);
    endtask

    task automatic drain(input logic [1:0] ph);
        int n = 0;
        cyc(1'b1, 1'b1, 1'b0, 1'b1, ph);
        while (m_state != S_IDLE && n < 8) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, ph);
            n++;
        end
        check("drain_idle", 32'(o_state), 32'(S_IDLE));
    endtask

    initial begin
        i_reset  = 1'b0;
        i_enable = 1'b0;
        i_start  = 1'b0;
        i_stop   = 1'b0;
        i_phase  = 2'd0;
        m_state  = S_IDLE;
        m_cnt    = 2'd0;
        m_phq    = 2'd0;
        m_win    = 3'd0;
        clr_logs();
        @(posedge clock);
        #1;

        // Held in reset: start is ignored, everything reads zero.
        repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
        check("reset_state", 32'(o_state), 32'(S_IDLE));
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 2'd0);

        // Start blocked by enable low and by simultaneous stop.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 2'd1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 2'd1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
        check("no_start_idle", 32'(o_busy), 32'd0);

        // Stop while armed returns to idle.
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 2'd1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 2'd1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
        check("arm_stop_idle", 32'(o_state), 32'(S_IDLE));

        // Basic run, phase 1, with a stray start at RUN cycle 6.
        start_run(2'd1);
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, (i == 6), 1'b0, 2'd1);
        check("basic_tx", tx_mask, 32'h0000_0888);
        check("basic_rx", rx_mask, 32'h0000_0222);
        drain(2'd1);

        // Phase change 1->3 at RUN cycle 5 takes effect at the next wrap.
        start_run(2'd1);
        for (int i = 0; i < 13; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, (i < 5) ? 2'd1 : 2'd3);
        check("phase_tx", tx_mask, 32'h0000_0888);
        check("phase_rx", rx_mask, 32'h0000_0822);
        drain(2'd3);

        // Stop at RUN cycle 4: one final tx at 7, idle from 8.
        start_run(2'd1);
        for (int i = 0; i < 13; i++) cyc(1'b1, 1'b1, 1'b0, (i == 4), 2'd1);
        check("stop_tx", tx_mask, 32'h0000_0088);
        check("stop_rx", rx_mask, 32'h0000_0002);
        check("stop_busy", busy_mask, 32'h0000_00FF);

        // Enable low for RUN cycles 2..4 delays the tx to cycle 6.
        start_run(2'd1);
        for (int i = 0; i < 10; i++) cyc(1'b1, !(i >= 2 && i <= 4), 1'b0, 1'b0, 2'd1);
        check("pause_tx", tx_mask, 32'h0000_0040);
        check("pause_rx", rx_mask, 32'h0000_0102);
        drain(2'd1);

        // Eight symbols: window done only on the 8th tx (when enabled).
        start_run(2'd2);
        for (int i = 0; i < 32; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 2'd2);
        check("win_tx", tx_mask, 32'h8888_8888);
        check("win_done", wd_mask, WIN_EN ? 32'h8000_0000 : 32'h0);
        drain(2'd2);

        // Reset asserted at RUN cycle 7 suppresses the tx that would fire.
        start_run(2'd1);
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
        check("rst_tx", tx_mask, 32'h0000_0008);
        check("rst_rx", rx_mask, 32'h0000_0022);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 2'd2);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 2'd2);
        check("rst_start_stop_idle", 32'(o_state), 32'(S_IDLE));

        // Clean restart after the abort.
        start_run(2'd0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        check("restart_tx", tx_mask, 32'h0000_0008);
        check("restart_rx", rx_mask, 32'h0000_0001);
        drain(2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sample_sched
